sha256_job_arbiter: RTL

Shares one simplified SHA-256 core between NUM_REQ requesters using round-robin arbitration. The arbiter latches the granted requester's message and output addresses, issues a one-cycle start to the core, and tracks the core's level-type done signal through a full clear/set cycle. It then returns a per-requester completion pulse. It sits between the requester bank and the core's start/done/address pins; the core alone drives the memory port.

---
 rtl/sha256_job_arbiter_pkg.sv | 26 ++
 rtl/sha256_job_arbiter_if.sv | 40 ++++
 rtl/sha256_job_arbiter_rr_pick.sv | 42 ++++
 rtl/sha256_job_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_job_arbiter_pkg.sv
// rtl/sha256_job_arbiter_pkg.sv - shared types and constants for the SHA-256 job arbiter
//
// Contents:
//   arb_state_e      arbiter FSM state encoding
//   ADDR_W_DEF       default word-address width of message/output pointers
//   WDOG_CYCLES_DEF  default watchdog limit in clk cycles
//   SHA256_H_INIT    SHA-256 initial hash words, shared with the core
package sha256_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_CLR = 3'd2,
    BUSY     = 3'd3,
    COMPLETE = 3'd4
  } arb_state_e;

  localparam int ADDR_W_DEF      = 16;
  localparam int WDOG_CYCLES_DEF = 4096;

  localparam logic [31:0] SHA256_H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_job_arbiter_if.sv
// rtl/sha256_job_arbiter_if.sv - requester-bank and core-pin bundle of the SHA-256 job arbiter
//
// Signals:
//   req, req_msg_addr, req_out_addr   requester bank -> arbiter
//   grant, req_done, req_err          arbiter -> requester bank
//   core_start, core_message_addr,
//   core_output_addr                  arbiter -> SHA-256 core
//   core_done                         SHA-256 core -> arbiter
// Modports:
//   master  arbiter side
//   slave   requester bank / core side
interface sha256_job_arbiter_if
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_msg_addr;
  logic [NUM_REQ*ADDR_W-1:0] req_out_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic                      core_start;
  logic [ADDR_W-1:0]         core_message_addr;
  logic [ADDR_W-1:0]         core_output_addr;
  logic                      core_done;

  modport master (
    input  req, req_msg_addr, req_out_addr, core_done,
    output grant, req_done, req_err, core_start, core_message_addr, core_output_addr
  );

  modport slave (
    output req, req_msg_addr, req_out_addr, core_done,
    input  grant, req_done, req_err, core_start, core_message_addr, core_output_addr
  );

endinterface

// File: rtl/sha256_job_arbiter_rr_pick.sv
// rtl/sha256_job_arbiter_rr_pick.sv - combinational round-robin selector
//
// Ports:
//   req       in   NUM_REQ  pending requests
//   last_ptr  in   IDX_W    index of the most recently served requester
//   gnt       out  NUM_REQ  one-hot winner (all zero when nothing pending)
//   idx       out  IDX_W    index of the winner
//   valid     out  1        a winner exists
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int         cand;
  logic [IDX_W-1:0] cand_idx;

  // Search starts one past last_ptr and wraps, so the requester served last
  // is considered only after every other one.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last_ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid         = 1'b1;
        idx           = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_job_arbiter.sv
// rtl/sha256_job_arbiter.sv - round-robin arbiter sharing one SHA-256 core between requesters
//
// Optional feature macro: SHA_ARB_WATCHDOG_EN (job watchdog, aborts with req_err)
//
// Ports:
//   clk        in   1        clock
//   reset_n    in   1        asynchronous active-low reset
//   bus        if   master   requester bank and core pins (see sha256_job_arbiter_if)
//   busy       out  1        high whenever the FSM is not in IDLE
//   jobs_done  out  16       completed-job counter, wraps
module sha256_job_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  sha256_job_arbiter_if.master        bus,
  output logic                        busy,
  output logic [15:0]                 jobs_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic [IDX_W-1:0]   last_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] req_done_q;
  logic               core_start_q;
  logic [ADDR_W-1:0]  msg_q, out_q;
  logic [ADDR_W-1:0]  msg_sel, out_sel;
  logic [15:0]        jobs_q;

  logic               do_grant;
  logic               do_complete;
  logic               do_abort;
  logic               wdog_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // Address slices of the winning requester; only used on the grant edge.
  always_comb begin
    msg_sel = '0;
    out_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        msg_sel = bus.req_msg_addr[i*ADDR_W +: ADDR_W];
        out_sel = bus.req_out_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    do_abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          do_grant = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_CLR;
      end
      // A done still high from the previous job must be seen low first,
      // otherwise the new job would complete immediately.
      WAIT_CLR: begin
        if (wdog_hit) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end else if (!bus.core_done) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wdog_hit) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end else if (bus.core_done) begin
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        do_complete = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      grant_q      <= '0;
      req_done_q   <= '0;
      core_start_q <= 1'b0;
      msg_q        <= '0;
      out_q        <= '0;
      jobs_q       <= '0;
    end else begin
      // Registered so the core sees start one cycle after grant, with the
      // address registers already stable.
      core_start_q <= (state_q == ISSUE);
      req_done_q   <= '0;
      if (do_grant) begin
        grant_q <= pick_gnt;
        owner_q <= pick_idx;
        msg_q   <= msg_sel;
        out_q   <= out_sel;
      end
      if (do_complete) begin
        req_done_q <= grant_q;
        jobs_q     <= jobs_q + 16'd1;
        last_ptr_q <= owner_q;
        grant_q    <= '0;
      end
      if (do_abort) begin
        last_ptr_q <= owner_q;
        grant_q    <= '0;
      end
    end
  end

`ifdef SHA_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

  logic [WD_W-1:0]    wdog_cnt_q;
  logic [NUM_REQ-1:0] req_err_q;

  // Counter value k-1 on the k-th edge spent in WAIT_CLR/BUSY, so the
  // abort edge lands exactly WDOG_CYCLES edges after ISSUE ends.
  assign wdog_hit = ((state_q == WAIT_CLR) || (state_q == BUSY)) &&
                    (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
      req_err_q  <= '0;
    end else begin
      req_err_q <= '0;
      if (do_grant) begin
        wdog_cnt_q <= '0;
      end else if ((state_q == WAIT_CLR) || (state_q == BUSY)) begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
      if (do_abort) begin
        req_err_q <= grant_q;
      end
    end
  end

  assign bus.req_err = req_err_q;
`else
  assign wdog_hit    = 1'b0;
  assign bus.req_err = '0;
`endif

  assign bus.grant             = grant_q;
  assign bus.req_done          = req_done_q;
  assign bus.core_start        = core_start_q;
  assign bus.core_message_addr = msg_q;
  assign bus.core_output_addr  = out_q;
  assign busy                  = (state_q != IDLE);
  assign jobs_done             = jobs_q;

endmodule
